// File: rtl/lbp_image_host.sv
// Host side of the LBP engine: loads the gray image, serves zero-latency reads, collects results, drains them.
// Optional build macro LBP_HOST_BORDER_CHECK_EN: engine writes to border pixels are flagged as errors and dropped.
module lbp_image_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_ready,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          err
);
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int IW    = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic          init_q;

  logic [7:0] gray_mem [DEPTH];
  logic [7:0] res_mem  [DEPTH];

  logic [IW-1:0] ptr_idx, gray_idx, lbp_idx;
  logic          gray_inr, lbp_inr, lbp_border;
  logic          load_fire, lbp_we, lbp_bad, fin_bad, gray_bad;

  assign ptr_idx  = ptr_q[IW-1:0];
  assign gray_idx = gray_addr[IW-1:0];
  assign lbp_idx  = lbp_addr[IW-1:0];
  assign gray_inr = {1'b0, gray_addr} < DEPTH_X;
  assign lbp_inr  = {1'b0, lbp_addr} < DEPTH_X;

`ifdef LBP_HOST_BORDER_CHECK_EN
  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_LAST = '1;
  localparam logic [IW-1:0] ROW_LAST = IW'(IMG_H - 1);
  logic [CW-1:0] lbp_col;
  logic [IW-1:0] lbp_row;
  assign lbp_col    = lbp_addr[CW-1:0];
  assign lbp_row    = lbp_idx >> CW;
  assign lbp_border = (lbp_col == '0) || (lbp_col == COL_LAST) ||
                      (lbp_row == '0) || (lbp_row == ROW_LAST);
`else
  assign lbp_border = 1'b0;
`endif

  // Only one writer per state, so the two res_mem sources never collide.
  assign load_fire = (state_q == S_LOAD) && init_q && load_valid;
  assign lbp_we    = lbp_valid && (state_q == S_SERVE) && lbp_inr && !lbp_border;
  assign lbp_bad   = lbp_valid && ((state_q != S_SERVE) || !lbp_inr || lbp_border);
  assign fin_bad   = finish && (state_q != S_SERVE);
  assign gray_bad  = gray_req && !gray_inr;

  always_ff @(posedge clk) begin
    if (load_fire) begin
      gray_mem[ptr_idx] <= load_data;
      res_mem[ptr_idx]  <= 8'h00;
    end else if (lbp_we) begin
      res_mem[lbp_idx]  <= lbp_data;
    end
  end

  assign gray_data = gray_inr ? gray_mem[gray_idx] : 8'h00;
  assign out_data  = res_mem[ptr_idx];
  assign out_last  = (state_q == S_DRAIN) && (ptr_q == LAST);
  assign err       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    err_d      = err_q | lbp_bad | fin_bad | gray_bad;
    load_ready = 1'b0;
    gray_ready = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_ready = init_q;
        if (load_fire) begin
          if (ptr_q == LAST) begin
            ptr_d   = '0;
            state_d = S_SERVE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_SERVE: begin
        gray_ready = 1'b1;
        if (finish) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (ptr_q == LAST) begin
            ptr_d   = '0;
            state_d = S_LOAD;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end
endmodule

// File: tb/tb_lbp_image_host.sv
// Directed bench for lbp_image_host on a 4x4 image with one spare address bit.
module tb_lbp_image_host;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int AW    = 5;
`ifdef LBP_HOST_BORDER_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [7:0]    load_data = '0;
  logic          load_ready;
  logic          gray_req = 1'b0;
  logic [AW-1:0] gray_addr = '0;
  logic          gray_ready;
  logic [7:0]    gray_data;
  logic          lbp_valid = 1'b0;
  logic [AW-1:0] lbp_addr = '0;
  logic [7:0]    lbp_data = '0;
  logic          finish = 1'b0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          err;

  int checks = 0;
  int errors = 0;
  logic [7:0] cap [16];

  lbp_image_host #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_frame(input logic [7:0] base);
    int k = 0;
    logic hs;
    for (int c = 0; c < 200 && k < 16; c++) begin
      load_valid = 1'b1;
      load_data  = base + 8'(k);
      hs = load_ready;
      tick();
      if (hs) k++;
    end
    load_valid = 1'b0;
    checks++;
    if (k != 16) begin
      $display("FAIL load_frame_timeout beats got %0d exp 16", k);
      errors++;
    end
  endtask

  task automatic drain_all;
    int n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 64 && n < 16; c++) begin
      if (out_valid) begin
        cap[n] = out_data;
        n++;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (n != 16) begin
      $display("FAIL drain_timeout beats got %0d exp 16", n);
      errors++;
    end
  endtask

  task automatic test_reset;
    tick();
    checks++; if (load_ready !== 1'b0) begin $display("FAIL rst_load_ready got %b exp 0", load_ready); errors++; end
    checks++; if (gray_ready !== 1'b0) begin $display("FAIL rst_gray_ready got %b exp 0", gray_ready); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %b exp 0", out_valid); errors++; end
    checks++; if (out_last !== 1'b0) begin $display("FAIL rst_out_last got %b exp 0", out_last); errors++; end
    checks++; if (err !== 1'b0) begin $display("FAIL rst_err got %b exp 0", err); errors++; end
    reset = 1'b0;
    checks++; if (load_ready !== 1'b0) begin $display("FAIL rst_first_cycle_ready got %b exp 0", load_ready); errors++; end
    tick();
    checks++; if (load_ready !== 1'b1) begin $display("FAIL rst_ready_after got %b exp 1", load_ready); errors++; end
  endtask

  task automatic test_load_burst;
    load_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      load_data = 8'(k);
      checks++; if (load_ready !== 1'b1) begin $display("FAIL burst_ready beat %0d got %b exp 1", k, load_ready); errors++; end
      checks++; if (gray_ready !== 1'b0) begin $display("FAIL burst_gray_ready beat %0d got %b exp 0", k, gray_ready); errors++; end
      tick();
    end
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) begin $display("FAIL burst_ready_drop got %b exp 0", load_ready); errors++; end
    checks++; if (gray_ready !== 1'b1) begin $display("FAIL burst_gray_ready got %b exp 1", gray_ready); errors++; end
    gray_addr = 5'd5;
    #1;
    checks++; if (gray_data !== 8'd5) begin $display("FAIL burst_gray5 got %0h exp 05", gray_data); errors++; end
    for (int k = 0; k < 16; k++) begin
      gray_addr = AW'(k);
      #1;
      checks++; if (gray_data !== 8'(k)) begin $display("FAIL burst_gray addr %0d got %0h exp %0h", k, gray_data, k); errors++; end
    end
  endtask

  task automatic test_serve_drain;
    logic [7:0] exp [16];
    for (int i = 0; i < 16; i++) exp[i] = 8'h00;
    exp[5] = 8'hAA; exp[6] = 8'h0F; exp[9] = 8'h33; exp[10] = 8'hFF;
    lbp_valid = 1'b1;
    lbp_addr = 5'd5;  lbp_data = 8'hAA; tick();
    lbp_addr = 5'd6;  lbp_data = 8'h0F; tick();
    lbp_addr = 5'd9;  lbp_data = 8'h33; tick();
    lbp_addr = 5'd10; lbp_data = 8'hFF; finish = 1'b1; tick();
    lbp_valid = 1'b0; finish = 1'b0;
    checks++; if (gray_ready !== 1'b0) begin $display("FAIL drain_gray_ready got %b exp 0", gray_ready); errors++; end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (out_valid !== 1'b1) begin $display("FAIL drain_valid beat %0d got %b exp 1", i, out_valid); errors++; end
      checks++; if (out_data !== exp[i]) begin $display("FAIL drain_data beat %0d got %0h exp %0h", i, out_data, exp[i]); errors++; end
      checks++; if (out_last !== logic'(i == 15)) begin $display("FAIL drain_last beat %0d got %b exp %b", i, out_last, i == 15); errors++; end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL drain_end_valid got %b exp 0", out_valid); errors++; end
    checks++; if (load_ready !== 1'b1) begin $display("FAIL drain_back_to_load got %b exp 1", load_ready); errors++; end
    checks++; if (err !== 1'b0) begin $display("FAIL drain_err got %b exp 0", err); errors++; end
  endtask

  task automatic test_load_toggle;
    for (int c = 0; c < 31; c++) begin
      load_valid = (c % 2 == 0);
      load_data  = (c % 2 == 0) ? 8'(8'h40 + c / 2) : 8'hEE;
      checks++; if (gray_ready !== 1'b0) begin $display("FAIL toggle_early_serve cycle %0d got %b exp 0", c, gray_ready); errors++; end
      tick();
    end
    load_valid = 1'b0;
    checks++; if (gray_ready !== 1'b1) begin $display("FAIL toggle_gray_ready got %b exp 1", gray_ready); errors++; end
    checks++; if (load_ready !== 1'b0) begin $display("FAIL toggle_load_ready got %b exp 0", load_ready); errors++; end
    for (int k = 0; k < 16; k++) begin
      gray_addr = AW'(k);
      #1;
      checks++; if (gray_data !== 8'(8'h40 + k)) begin $display("FAIL toggle_gray addr %0d got %0h exp %0h", k, gray_data, 8'h40 + k); errors++; end
    end
  endtask

  task automatic test_drain_stall;
    logic [7:0] exp [16];
    logic pat [4];
    int idx = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 16; i++) exp[i] = 8'h00;
    exp[6] = 8'h5A;
    lbp_valid = 1'b1; lbp_addr = 5'd6; lbp_data = 8'h5A; finish = 1'b1;
    tick();
    lbp_valid = 1'b0; finish = 1'b0;
    for (int c = 0; c < 100 && idx < 16; c++) begin
      out_ready = pat[c % 4];
      checks++; if (out_valid !== 1'b1) begin $display("FAIL stall_valid beat %0d got %b exp 1", idx, out_valid); errors++; end
      checks++; if (out_data !== exp[idx]) begin $display("FAIL stall_data beat %0d got %0h exp %0h", idx, out_data, exp[idx]); errors++; end
      checks++; if (out_last !== logic'(idx == 15)) begin $display("FAIL stall_last beat %0d got %b exp %b", idx, out_last, idx == 15); errors++; end
      tick();
      if (out_ready) idx++;
    end
    out_ready = 1'b0;
    checks++; if (idx != 16) begin $display("FAIL stall_count got %0d exp 16", idx); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL stall_end_valid got %b exp 0", out_valid); errors++; end
  endtask

  task automatic test_border;
    logic [7:0] exp3;
    logic       exp_err;
    exp3    = BCHK ? 8'h00 : 8'h77;
    exp_err = BCHK;
    do_reset();
    load_frame(8'h10);
    lbp_valid = 1'b1; lbp_addr = 5'd3; lbp_data = 8'h77; tick();
    lbp_addr = 5'd5; lbp_data = 8'h66; tick();
    lbp_valid = 1'b0;
    checks++; if (err !== exp_err) begin $display("FAIL border_err got %b exp %b", err, exp_err); errors++; end
    finish = 1'b1; tick(); finish = 1'b0;
    drain_all();
    checks++; if (cap[3] !== exp3) begin $display("FAIL border_beat3 got %0h exp %0h", cap[3], exp3); errors++; end
    checks++; if (cap[5] !== 8'h66) begin $display("FAIL border_beat5 got %0h exp 66", cap[5]); errors++; end
    checks++; if (cap[0] !== 8'h00) begin $display("FAIL border_beat0 got %0h exp 00", cap[0]); errors++; end
  endtask

  task automatic test_protocol_err;
    do_reset();
    lbp_valid = 1'b1; lbp_addr = 5'd5; lbp_data = 8'h12; tick(); lbp_valid = 1'b0;
    checks++; if (err !== 1'b1) begin $display("FAIL err_lbp_in_load got %b exp 1", err); errors++; end
    do_reset();
    checks++; if (err !== 1'b0) begin $display("FAIL err_cleared got %b exp 0", err); errors++; end
    finish = 1'b1; tick(); finish = 1'b0;
    checks++; if (err !== 1'b1) begin $display("FAIL err_finish_in_load got %b exp 1", err); errors++; end
    do_reset();
    load_frame(8'h00);
    gray_addr = 5'd20;
    #1;
    checks++; if (gray_data !== 8'h00) begin $display("FAIL oor_gray_data got %0h exp 00", gray_data); errors++; end
    checks++; if (err !== 1'b0) begin $display("FAIL oor_no_req_err got %b exp 0", err); errors++; end
    gray_req = 1'b1; tick(); gray_req = 1'b0;
    checks++; if (err !== 1'b1) begin $display("FAIL oor_gray_err got %b exp 1", err); errors++; end
    do_reset();
    load_frame(8'h00);
    lbp_valid = 1'b1; lbp_addr = 5'd17; lbp_data = 8'h99; tick(); lbp_valid = 1'b0;
    checks++; if (err !== 1'b1) begin $display("FAIL oor_lbp_err got %b exp 1", err); errors++; end
    finish = 1'b1; tick(); finish = 1'b0;
    drain_all();
    checks++; if (cap[1] !== 8'h00) begin $display("FAIL oor_lbp_dropped got %0h exp 00", cap[1]); errors++; end
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    load_frame(8'h00);
    finish = 1'b1; tick(); finish = 1'b0;
    out_ready = 1'b1;
    repeat (7) tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin $display("FAIL mid_pre_valid got %b exp 1", out_valid); errors++; end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin $display("FAIL mid_out_valid got %b exp 0", out_valid); errors++; end
    checks++; if (gray_ready !== 1'b0) begin $display("FAIL mid_gray_ready got %b exp 0", gray_ready); errors++; end
    checks++; if (out_last !== 1'b0) begin $display("FAIL mid_out_last got %b exp 0", out_last); errors++; end
    tick();
    reset = 1'b0;
    load_frame(8'h20);
    checks++; if (gray_ready !== 1'b1) begin $display("FAIL mid_reload_ready got %b exp 1", gray_ready); errors++; end
    gray_addr = 5'd0;
    #1;
    checks++; if (gray_data !== 8'h20) begin $display("FAIL mid_reload_px0 got %0h exp 20", gray_data); errors++; end
    gray_addr = 5'd7;
    #1;
    checks++; if (gray_data !== 8'h27) begin $display("FAIL mid_reload_px7 got %0h exp 27", gray_data); errors++; end
  endtask

  initial begin
    test_reset();
    test_load_burst();
    test_serve_drain();
    test_load_toggle();
    test_drain_stall();
    test_border();
    test_protocol_err();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
